mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DBITS, 32, datapath and address width
  REG_BITS, 4, register index width
  TIMEOUT, 16, max cycles waiting for memReady (>=2)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  inValid  in  1  execute result present
  inReady  out  1  stage can accept this cycle
  aluResult  in  DBITS  ALU output (data or memory address)
  condResult  in  1  conditional-check output
  storeData  in  DBITS  second-register value for stores
  destReg  in  REG_BITS  destination register index
  isLoad  in  1  instruction is a load
  isStore  in  1  instruction is a store
  isBranch  in  1  instruction is a conditional branch
  regWrite  in  1  instruction writes destReg
  memAddr  out  DBITS  data-memory address
  memWrData  out  DBITS  data-memory write data
  memRd  out  1  read request, held until done
  memWr  out  1  write request, held until done
  memReady  in  1  memory completes the request this cycle
  memRdData  in  DBITS  read data, valid with memReady
  wbValid  out  1  one-cycle pulse per retired instruction
  wbWrite  out  1  write wbData to wbReg (qualified by wbValid)
  wbReg  out  REG_BITS  writeback register index
  wbData  out  DBITS  writeback value
  branchTaken  out  1  isBranch AND condResult of retired instruction
  memError  out  1  sticky error flag

Function
REQ-003 The FSM SHALL have states IDLE and WAIT; inReady SHALL be 1 in IDLE and 0 in WAIT; accept = inValid AND inReady.
REQ-004 Accepted non-memory op: next cycle wbValid=1, wbData=aluResult, wbReg=destReg, wbWrite=regWrite, branchTaken=isBranch&condResult; state stays IDLE, giving throughput of 1 per cycle.
REQ-005 Accepted load/store with aluResult[1:0]=00: next state WAIT; memAddr=aluResult, memWrData=storeData, memRd=isLoad, memWr=isStore, all registered and held stable through WAIT.
REQ-006 In WAIT with memReady=1: clear memRd/memWr, return to IDLE; next cycle wbValid=1 with wbData=memRdData (captured at memReady) for loads, or wbWrite=0 for stores.
REQ-007 The wait counter SHALL reset to 0 on entering WAIT and increment each WAIT cycle without memReady; at count TIMEOUT-1 without memReady: clear requests, set memError, retire with wbWrite=0, return to IDLE.
REQ-008 Load/store with aluResult[1:0]!=00, or isLoad AND isStore both set: no memory request; set memError; retire next cycle with wbWrite=0; state stays IDLE.
REQ-009 memReady outside WAIT SHALL be ignored; memReady on the timeout cycle SHALL count as success.
REQ-010 wbValid, wbWrite and branchTaken SHALL be 0 on cycles without retirement; wbData/wbReg hold their last values.
REQ-011 memError SHALL stay 1 until reset and SHALL NOT block further operation.

Reset
REQ-012 reset SHALL force IDLE, counter=0, and memRd, memWr, wbValid, wbWrite, branchTaken, memError, memAddr, memWrData, wbData, wbReg=0; reset in WAIT SHALL abort the request with no retirement.

Structure
REQ-013 FSM state encodings and the alignment-mask constant SHALL live in the shared processor package/header; no sub-module is required, and the wait counter MAY be a sub-module named wait_counter.

Verification
REQ-014 Back-to-back ALU ops aluResult=5,7,9 on consecutive cycles -> wbValid three consecutive cycles, wbData=5,7,9.
REQ-015 Load at 0x100, memReady 3 cycles later, memRdData=0xDEADBEEF -> inReady=0 for 3 cycles; then wbValid with wbData=0xDEADBEEF and wbWrite=1.
REQ-016 Store at 0x102 -> no memWr, memError=1, wbValid with wbWrite=0 next cycle.
REQ-017 Load, memReady never asserted, TIMEOUT=16 -> memRd high for exactly 16 cycles, then memError=1 and retire with wbWrite=0.
REQ-018 Branch with condResult=1, and reset asserted during WAIT of a following store -> branchTaken=1 pulse; after reset memWr=0, all outputs 0, no retirement.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
//   Shared constants for the memory-access pipeline stage.
//   - FSM state encodings (kept as plain constants for compatibility with
//     existing headers that compare state values numerically)
//   - word-alignment mask for data-memory addresses
//   - helper that flags a misaligned word address
package mem_access_stage_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic isMisaligned(input logic [1:0] addrLow);
    return (addrLow & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Bundles the execute-side handshake, the data-memory bus and the
//   writeback outputs of the memory-access stage.
//   Parameters: DBITS (datapath/address width), REG_BITS (register index width)
//   Modports:
//     slave  - the stage itself (consumes execute results and memory
//              responses, drives memory requests and writeback)
//     master - the surrounding pipeline / memory model
interface mem_access_stage_if #(
  parameter int DBITS    = 32,
  parameter int REG_BITS = 4
);
  import mem_access_stage_pkg::*;

  // execute -> stage
  logic                inValid;
  logic                inReady;
  logic [DBITS-1:0]    aluResult;
  logic                condResult;
  logic [DBITS-1:0]    storeData;
  logic [REG_BITS-1:0] destReg;
  logic                isLoad;
  logic                isStore;
  logic                isBranch;
  logic                regWrite;

  // stage <-> data memory
  logic [DBITS-1:0]    memAddr;
  logic [DBITS-1:0]    memWrData;
  logic                memRd;
  logic                memWr;
  logic                memReady;
  logic [DBITS-1:0]    memRdData;

  // stage -> writeback
  logic                wbValid;
  logic                wbWrite;
  logic [REG_BITS-1:0] wbReg;
  logic [DBITS-1:0]    wbData;
  logic                branchTaken;
  logic                memError;

  modport slave (
    input  inValid, aluResult, condResult, storeData, destReg,
           isLoad, isStore, isBranch, regWrite, memReady, memRdData,
    output inReady, memAddr, memWrData, memRd, memWr,
           wbValid, wbWrite, wbReg, wbData, branchTaken, memError
  );

  modport master (
    output inValid, aluResult, condResult, storeData, destReg,
           isLoad, isStore, isBranch, regWrite, memReady, memRdData,
    input  inReady, memAddr, memWrData, memRd, memWr,
           wbValid, wbWrite, wbReg, wbData, branchTaken, memError
  );

endinterface

// File: rtl/mem_access_stage_wait_counter.sv
// wait_counter
//   Counts cycles spent waiting for a data-memory response.
//   Ports:
//     clk, reset - clock, synchronous active-high reset
//     clear      - restart the count at 0 (request being issued)
//     enable     - advance by one (waiting cycle without a response)
//     atLimit    - count has reached TIMEOUT-1
module wait_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic atLimit
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign atLimit = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory-access pipeline stage. Non-memory results retire one cycle after
//   acceptance at full throughput; aligned loads/stores issue a held request
//   to data memory and stall (inReady=0) until memReady or a timeout.
//   Misaligned or load+store-conflicting ops raise the sticky memError and
//   retire without a register write.
//   Parameters: DBITS, REG_BITS, TIMEOUT (>=2, max WAIT cycles)
//   Ports:
//     clk   - single clock, all state on rising edge
//     reset - synchronous active-high reset
//     bus   - mem_access_stage_if.slave (execute handshake, memory bus,
//             writeback outputs)
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DBITS    = 32,
  parameter int REG_BITS = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_stage_if.slave   bus
);

  logic [0:0]          state;
  logic                pendLoad;
  logic                pendWrite;
  logic                pendBranch;
  logic [REG_BITS-1:0] pendReg;

  logic accept;
  logic isMemOp;
  logic badMemOp;
  logic startWait;
  logic waitTick;
  logic atLimit;

  assign bus.inReady = (state == ST_IDLE);
  assign accept      = bus.inValid & bus.inReady;
  assign isMemOp     = bus.isLoad | bus.isStore;
  assign badMemOp    = isMisaligned(bus.aluResult[1:0]) | (bus.isLoad & bus.isStore);
  assign startWait   = accept & isMemOp & ~badMemOp;
  assign waitTick    = (state == ST_WAIT) & ~bus.memReady;

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) uWaitCounter (
    .clk     (clk),
    .reset   (reset),
    .clear   (startWait),
    .enable  (waitTick),
    .atLimit (atLimit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      pendLoad        <= 1'b0;
      pendWrite       <= 1'b0;
      pendBranch      <= 1'b0;
      pendReg         <= '0;
      bus.memAddr     <= '0;
      bus.memWrData   <= '0;
      bus.memRd       <= 1'b0;
      bus.memWr       <= 1'b0;
      bus.wbValid     <= 1'b0;
      bus.wbWrite     <= 1'b0;
      bus.wbReg       <= '0;
      bus.wbData      <= '0;
      bus.branchTaken <= 1'b0;
      bus.memError    <= 1'b0;
    end else begin
      // retirement strobes are single-cycle; data/index hold last value
      bus.wbValid     <= 1'b0;
      bus.wbWrite     <= 1'b0;
      bus.branchTaken <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!isMemOp) begin
              bus.wbValid     <= 1'b1;
              bus.wbWrite     <= bus.regWrite;
              bus.wbReg       <= bus.destReg;
              bus.wbData      <= bus.aluResult;
              bus.branchTaken <= bus.isBranch & bus.condResult;
            end else if (badMemOp) begin
              // rejected before any request reaches memory
              bus.memError    <= 1'b1;
              bus.wbValid     <= 1'b1;
              bus.wbWrite     <= 1'b0;
              bus.wbReg       <= bus.destReg;
              bus.wbData      <= bus.aluResult;
              bus.branchTaken <= bus.isBranch & bus.condResult;
            end else begin
              state         <= ST_WAIT;
              bus.memAddr   <= bus.aluResult;
              bus.memWrData <= bus.storeData;
              bus.memRd     <= bus.isLoad;
              bus.memWr     <= bus.isStore;
              pendLoad      <= bus.isLoad;
              pendWrite     <= bus.regWrite;
              pendBranch    <= bus.isBranch & bus.condResult;
              pendReg       <= bus.destReg;
            end
          end
        end

        ST_WAIT: begin
          // memReady wins over the timeout when both land on the same cycle
          if (bus.memReady) begin
            state           <= ST_IDLE;
            bus.memRd       <= 1'b0;
            bus.memWr       <= 1'b0;
            bus.wbValid     <= 1'b1;
            bus.wbWrite     <= pendLoad & pendWrite;
            bus.wbReg       <= pendReg;
            bus.branchTaken <= pendBranch;
            if (pendLoad) begin
              bus.wbData <= bus.memRdData;
            end
          end else if (atLimit) begin
            state           <= ST_IDLE;
            bus.memRd       <= 1'b0;
            bus.memWr       <= 1'b0;
            bus.memError    <= 1'b1;
            bus.wbValid     <= 1'b1;
            bus.wbWrite     <= 1'b0;
            bus.wbReg       <= pendReg;
            bus.branchTaken <= pendBranch;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int DBITS    = 32;
  localparam int REG_BITS = 4;
  localparam int TIMEOUT  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_stage_if #(.DBITS(DBITS), .REG_BITS(REG_BITS)) bus ();

  mem_access_stage #(
    .DBITS    (DBITS),
    .REG_BITS (REG_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] alu;
    logic [3:0]  dest;
    logic        regWrite;
    logic        isBranch;
    logic        cond;
    logic        isLoad;
    logic        isStore;
    logic        expWrite;
    logic        expBranch;
    logic        expErr;
    logic        chkData;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [3:0]  rg;
    logic [31:0] data;
    logic        chkData;
    logic        br;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon;
  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard consumer: every retirement pops one expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wbValid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_retire: got wbValid=1 expected no retirement (cycle %0d)", cyc);
        end else begin
          mon = sb.pop_front();
          chk("wbWrite", {63'd0, bus.wbWrite}, {63'd0, mon.wr});
          chk("branchTaken", {63'd0, bus.branchTaken}, {63'd0, mon.br});
          chk("memError_at_retire", {63'd0, bus.memError}, {63'd0, mon.err});
          if (mon.chkData) begin
            chk("wbReg", {60'd0, bus.wbReg}, {60'd0, mon.rg});
            chk("wbData", {32'd0, bus.wbData}, {32'd0, mon.data});
          end
          if (mon.cyc >= 0) chk("retire_cycle", 64'(cyc), 64'(mon.cyc));
        end
      end else begin
        chk("idle_strobes", {62'd0, bus.wbWrite, bus.branchTaken}, 64'd0);
      end
    end
  end

  task automatic clearInputs();
    bus.inValid    = 1'b0;
    bus.aluResult  = '0;
    bus.condResult = 1'b0;
    bus.storeData  = '0;
    bus.destReg    = '0;
    bus.isLoad     = 1'b0;
    bus.isStore    = 1'b0;
    bus.isBranch   = 1'b0;
    bus.regWrite   = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_inReady"}, {63'd0, bus.inReady}, 64'd1);
    chk({tag, "_strobes"}, {58'd0, bus.memRd, bus.memWr, bus.wbValid, bus.wbWrite,
                            bus.branchTaken, bus.memError}, 64'd0);
    chk({tag, "_memAddr"}, {32'd0, bus.memAddr}, 64'd0);
    chk({tag, "_memWrData"}, {32'd0, bus.memWrData}, 64'd0);
    chk({tag, "_wbData"}, {32'd0, bus.wbData}, 64'd0);
    chk({tag, "_wbReg"}, {60'd0, bus.wbReg}, 64'd0);
  endtask

  // drive one single-cycle op (caller deasserts inValid) and queue its result
  task automatic applyVec(input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    bus.aluResult  = v.alu;
    bus.destReg    = v.dest;
    bus.regWrite   = v.regWrite;
    bus.isBranch   = v.isBranch;
    bus.condResult = v.cond;
    bus.isLoad     = v.isLoad;
    bus.isStore    = v.isStore;
    bus.storeData  = 32'h5555_AAAA;
    bus.inValid    = 1'b1;
    e.wr = v.expWrite; e.rg = v.dest; e.data = v.alu; e.chkData = v.chkData;
    e.br = v.expBranch; e.err = v.expErr; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  // aligned load/store; readyAfter = WAIT cycle on which memReady is raised, 0 = never
  task automatic memOp(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic [3:0] dest,
                       input int readyAfter, input logic expErr);
    exp_t e;
    int lowCnt = 0;
    int reqCnt = 0;
    int unstable = 0;
    int expCnt;
    logic done = 1'b0;
    expCnt = (readyAfter != 0) ? readyAfter : TIMEOUT;
    @(posedge clk); #1;
    bus.aluResult = addr;
    bus.storeData = wdata;
    bus.destReg   = dest;
    bus.regWrite  = ld;
    bus.isLoad    = ld;
    bus.isStore   = ~ld;
    bus.isBranch  = 1'b0;
    bus.inValid   = 1'b1;
    e.wr = ld & (readyAfter != 0); e.rg = dest; e.data = rdata;
    e.chkData = ld & (readyAfter != 0); e.br = 1'b0; e.err = expErr; e.cyc = -1;
    sb.push_back(e);
    @(posedge clk); #1;
    clearInputs();
    bus.aluResult = 32'hFFFF_FFFF;
    bus.storeData = 32'h0BAD_0BAD;
    bus.memRdData = 32'h0BAD_F00D;
    for (int c = 0; c < TIMEOUT + 4 && !done; c++) begin
      @(negedge clk);
      if (!bus.inReady) begin
        lowCnt++;
        if ((ld ? bus.memRd : bus.memWr) && !(ld ? bus.memWr : bus.memRd)) reqCnt++;
        if (bus.memAddr !== addr || (!ld && bus.memWrData !== wdata)) unstable++;
        if (lowCnt == readyAfter) begin
          bus.memReady  = 1'b1;
          bus.memRdData = rdata;
        end
      end else begin
        done = 1'b1;
        bus.memReady  = 1'b0;
        bus.memRdData = 32'h0BAD_F00D;
      end
    end
    bus.memReady = 1'b0;
    chk("wait_returned", {63'd0, done}, 64'd1);
    chk("inReady_low_cycles", 64'(lowCnt), 64'(expCnt));
    chk("request_cycles", 64'(reqCnt), 64'(expCnt));
    chk("request_stable", 64'(unstable), 64'd0);
    chk("request_cleared", {62'd0, bus.memRd, bus.memWr}, 64'd0);
  endtask

  initial begin
    clearInputs();
    bus.memReady  = 1'b0;
    bus.memRdData = '0;

    //                  alu           dest  rw    br    cond  ld    st    eW    eB    eErr  chkD
    vecs[0] = '{32'd5,        4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'd7,        4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'd9,        4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h40,       4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h44,       4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h11,       4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h102,      4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h200,      4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h13,       4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    // single-cycle ops back to back; memReady held high must be ignored in IDLE
    bus.memReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      applyVec(vecs[i]);
      @(negedge clk);
      chk("table_inReady", {63'd0, bus.inReady}, 64'd1);
      chk("table_no_request", {62'd0, bus.memRd, bus.memWr}, 64'd0);
    end
    @(posedge clk); #1;
    clearInputs();
    bus.memReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("memError_sticky", {63'd0, bus.memError}, 64'd1);

    doReset();
    @(negedge clk);
    checkAllZero("reset2");

    memOp(1'b1, 32'h100, 32'h0,         32'hDEADBEEF, 4'd9,  3,       1'b0);
    memOp(1'b0, 32'h104, 32'hCAFEF00D,  32'h0,        4'd10, 1,       1'b0);
    memOp(1'b1, 32'h10C, 32'h0,         32'h12345678, 4'd11, TIMEOUT, 1'b0);
    memOp(1'b1, 32'h110, 32'h0,         32'h0,        4'd12, 0,       1'b1);
    applyVec('{32'h77, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1 clearInputs();
    repeat (2) @(negedge clk);

    // taken branch, then a store aborted by reset while waiting
    doReset();
    applyVec('{32'h80, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    @(posedge clk); #1;
    clearInputs();
    bus.aluResult = 32'h108;
    bus.storeData = 32'hA5A5A5A5;
    bus.isStore   = 1'b1;
    bus.inValid   = 1'b1;
    @(posedge clk); #1 clearInputs();
    @(negedge clk);
    chk("abort_store_issued", {62'd0, bus.memWr, bus.inReady}, 64'd2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkAllZero("abort");
    repeat (TIMEOUT + 2) @(negedge clk);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
